// File: rtl/imem_latency_model_if.sv
// Fetch-side bundle between a fetch unit (master) and the latency model (slave).
// Covers the request, backing-store lookup, response and flush signals.
interface imem_latency_model_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            req_vld;
    logic [XLEN-1:0] req_addr;
    logic            req_rdy;
    logic [XLEN-1:0] mem_addr;
    logic [31:0]     mem_rd_data;
    logic            flush;
    logic            rsp_vld;
    logic [XLEN-1:0] rsp_addr;
    logic [31:0]     rsp_data;
    logic            rsp_rdy;
    logic [CntW-1:0] outstanding;

    modport master (
        output req_vld, req_addr, mem_rd_data, flush, rsp_rdy,
        input  req_rdy, mem_addr, rsp_vld, rsp_addr, rsp_data, outstanding
    );

    modport slave (
        input  req_vld, req_addr, mem_rd_data, flush, rsp_rdy,
        output req_rdy, mem_addr, rsp_vld, rsp_addr, rsp_data, outstanding
    );
endinterface

// File: rtl/imem_latency_model.sv
// Instruction-memory latency model: fixed-latency delay line feeding an in-order
// response FIFO, with credit-based request flow control and a single-edge flush.
module imem_latency_model #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DEPTH   = 4
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    imem_latency_model_if.slave   bus
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [31:0]     data;
    } ent_t;

    logic            accept;
    logic            consume;
    logic            flush;
    logic            rd;
    logic            wr_vld;
    ent_t            wr_ent;
    ent_t            fifo_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wbase;
    logic [CntW-1:0] cnt_q, cnt_d, out_q, out_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrOne;
    endfunction

    assign flush           = bus.flush;
    assign bus.req_rdy     = i_rst_n && ((out_q < DepthC) || flush);
    assign accept          = bus.req_vld && bus.req_rdy;
    assign bus.rsp_vld     = (cnt_q != '0);
    assign consume         = bus.rsp_vld && bus.rsp_rdy;
    assign bus.mem_addr    = bus.req_addr;
    assign bus.rsp_addr    = bus.rsp_vld ? fifo_q[rptr_q].addr : '0;
    assign bus.rsp_data    = bus.rsp_vld ? fifo_q[rptr_q].data : '0;
    assign bus.outstanding = out_q;

    // The FIFO write is the last delay stage, so only LATENCY-1 registers precede it.
    if (LATENCY == 1) begin : g_direct
        assign wr_vld = accept;
        assign wr_ent = {bus.req_addr, bus.mem_rd_data};
    end else begin : g_pipe
        localparam int unsigned Stages = LATENCY - 1;
        logic [Stages-1:0] vld_q;
        ent_t              ent_q [Stages];

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int i = 1; i < Stages; i++) begin
                    vld_q[i] <= vld_q[i-1] && !flush;
                end
            end
        end

        always_ff @(posedge i_clk) begin
            ent_q[0] <= {bus.req_addr, bus.mem_rd_data};
            for (int i = 1; i < Stages; i++) begin
                ent_q[i] <= ent_q[i-1];
            end
        end

        assign wr_vld = vld_q[Stages-1] && !flush;
        assign wr_ent = ent_q[Stages-1];
    end

    always_comb begin
        wbase  = flush ? '0 : wptr_q;
        rptr_d = flush ? '0 : rptr_q;
        cnt_d  = flush ? '0 : cnt_q;
        rd     = consume && !flush;
        wptr_d = wr_vld ? ptr_inc(wbase) : wbase;
        if (rd) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (wr_vld && !rd) begin
            cnt_d = cnt_d + CntOne;
        end else if (rd && !wr_vld) begin
            cnt_d = cnt_d - CntOne;
        end

        // A flush wipes all credit; only a request riding on the flush survives.
        out_d = out_q;
        if (flush) begin
            out_d = accept ? CntOne : '0;
        end else if (accept && !consume) begin
            out_d = out_q + CntOne;
        end else if (consume && !accept) begin
            out_d = out_q - CntOne;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_vld) begin
            fifo_q[wbase] <= wr_ent;
        end
    end
endmodule

// File: tb/tb_imem_latency_model.sv
// Drives three differently-configured instances with one shared stimulus stream and
// checks each against a queue-based model of acceptance time, latency and order.
module tb_imem_latency_model;
    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        flush;
    logic        rsp_rdy;
    logic [31:0] req_addr;
    logic [31:0] mem_data;

    logic [2:0]  o_rdy;
    logic [2:0]  o_vld;
    logic [31:0] o_addr  [3];
    logic [31:0] o_data  [3];
    logic [31:0] o_maddr [3];
    logic [7:0]  o_out   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam int unsigned D = (g == 2) ? 3 : 4;

        imem_latency_model_if #(.XLEN(32), .DEPTH(D)) bus ();

        imem_latency_model #(.XLEN(32), .LATENCY(L), .DEPTH(D)) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus)
        );

        assign bus.req_vld     = req_vld;
        assign bus.req_addr    = req_addr;
        assign bus.mem_rd_data = mem_data;
        assign bus.flush       = flush;
        assign bus.rsp_rdy     = rsp_rdy;
        assign o_rdy[g]        = bus.req_rdy;
        assign o_vld[g]        = bus.rsp_vld;
        assign o_addr[g]       = bus.rsp_addr;
        assign o_data[g]       = bus.rsp_data;
        assign o_maddr[g]      = bus.mem_addr;
        assign o_out[g]        = 8'(bus.outstanding);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance a queue of (addr, data, first-visible cycle).
    int          lat [3] = '{1, 3, 2};
    int          dep [3] = '{4, 4, 3};
    logic [31:0] ea  [3][64];
    logic [31:0] ed  [3][64];
    int          et  [3][64];
    int          hd  [3];
    int          tl  [3];
    int          cyc;
    logic        x_rdy  [3];
    logic        x_vld  [3];
    logic [31:0] x_addr [3];
    logic [31:0] x_data [3];
    int          x_out  [3];

    int checks;
    int errors;
    bit chk_en;

    task automatic chk(input string tag, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, got, exp);
        end
    endtask

    task automatic predict();
        for (int i = 0; i < 3; i++) begin
            int sz;
            sz        = tl[i] - hd[i];
            x_vld[i]  = (sz > 0) && (et[i][hd[i] % 64] <= cyc);
            x_addr[i] = x_vld[i] ? ea[i][hd[i] % 64] : 32'h0;
            x_data[i] = x_vld[i] ? ed[i][hd[i] % 64] : 32'h0;
            x_rdy[i]  = rst_n && ((sz < dep[i]) || flush);
            x_out[i]  = sz;
        end
    endtask

    // One clock: compare outputs at the falling edge, then advance the model.
    task automatic step();
        @(negedge clk);
        predict();
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("req_rdy", i, {31'h0, o_rdy[i]}, {31'h0, x_rdy[i]});
                chk("rsp_vld", i, {31'h0, o_vld[i]}, {31'h0, x_vld[i]});
                chk("rsp_addr", i, o_addr[i], x_addr[i]);
                chk("rsp_data", i, o_data[i], x_data[i]);
                chk("outstanding", i, {24'h0, o_out[i]}, 32'(x_out[i]));
                chk("mem_addr", i, o_maddr[i], req_addr);
            end
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            bit acc, con;
            acc = req_vld && x_rdy[i];
            con = x_vld[i] && rsp_rdy;
            if (!rst_n) begin
                hd[i] = 0;
                tl[i] = 0;
            end else begin
                if (flush) hd[i] = tl[i];
                else if (con) hd[i]++;
                if (acc) begin
                    ea[i][tl[i] % 64] = req_addr;
                    ed[i][tl[i] % 64] = mem_data;
                    et[i][tl[i] % 64] = cyc + lat[i] - 1;
                    tl[i]++;
                end
            end
        end
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        chk_en   = 1'b0;
        hd       = '{0, 0, 0};
        tl       = '{0, 0, 0};
        rst_n    = 1'b0;
        req_vld  = 1'b0;
        flush    = 1'b0;
        rsp_rdy  = 1'b0;
        req_addr = 32'h0;
        mem_data = 32'h0;
        step();
        chk_en = 1'b1;
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        rst_n = 1'b1;
        step();

        // Back-to-back fetches; the L=1 instance streams without bubbles.
        rsp_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_vld  = 1'b1;
            req_addr = 32'(4 * k);
            mem_data = 32'h13 + 32'(32'h80 * k);
            step();
        end
        chk("l1_stream_vld", 0, {31'h0, o_vld[0]}, 32'h1);
        chk("l1_stream_addr", 0, o_addr[0], 32'h8);
        chk("l1_stream_data", 0, o_data[0], 32'h113);
        req_vld = 1'b0;
        repeat (4) step();

        // Single fetch through the 3-cycle instance.
        req_vld  = 1'b1;
        req_addr = 32'h100;
        mem_data = 32'hDEADBEEF;
        step();
        req_vld = 1'b0;
        step();
        chk("l3_early_vld", 1, {31'h0, o_vld[1]}, 32'h0);
        step();
        chk("l3_vld", 1, {31'h0, o_vld[1]}, 32'h1);
        chk("l3_addr", 1, o_addr[1], 32'h100);
        chk("l3_data", 1, o_data[1], 32'hDEADBEEF);
        repeat (3) step();

        // Fill to credit limit with the consumer stalled, then drain.
        rsp_rdy = 1'b0;
        req_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_addr = $urandom & 32'hFFFF_FFFC;
            mem_data = $urandom;
            step();
        end
        chk("full_out", 0, {24'h0, o_out[0]}, 32'h4);
        chk("full_rdy", 0, {31'h0, o_rdy[0]}, 32'h0);
        chk("full_out", 2, {24'h0, o_out[2]}, 32'h3);
        chk("full_rdy", 2, {31'h0, o_rdy[2]}, 32'h0);
        rsp_rdy = 1'b1;
        req_vld = 1'b0;
        step();
        chk("credit_back", 0, {31'h0, o_rdy[0]}, 32'h1);
        repeat (6) step();

        // Flush with a request riding on it.
        req_vld = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_addr = 32'(4 * k);
            mem_data = 32'h1000 + 32'(k);
            step();
        end
        flush    = 1'b1;
        req_addr = 32'h80;
        mem_data = 32'h80;
        step();
        flush   = 1'b0;
        req_vld = 1'b0;
        chk("flush_out", 1, {24'h0, o_out[1]}, 32'h1);
        chk("flush_vld", 1, {31'h0, o_vld[1]}, 32'h0);
        step();
        chk("flush_early", 1, {31'h0, o_vld[1]}, 32'h0);
        step();
        chk("flush_vld2", 1, {31'h0, o_vld[1]}, 32'h1);
        chk("flush_addr", 1, o_addr[1], 32'h80);
        repeat (3) step();

        // Random traffic with stalls and occasional flushes.
        for (int k = 0; k < 80; k++) begin
            req_vld  = ($urandom % 4) != 0;
            req_addr = $urandom & 32'hFFFF_FFFC;
            mem_data = $urandom;
            rsp_rdy  = ($urandom % 3) != 0;
            flush    = ($urandom % 20) == 0;
            step();
        end
        flush   = 1'b0;
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        repeat (8) step();

        // Reset with responses outstanding.
        rsp_rdy = 1'b0;
        req_vld = 1'b1;
        repeat (2) step();
        req_vld = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_vld", i, {31'h0, o_vld[i]}, 32'h0);
            chk("rst_out", i, {24'h0, o_out[i]}, 32'h0);
        end
        rst_n   = 1'b1;
        rsp_rdy = 1'b1;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
